array_launcher: RTL and testbench
=================================

ARRAY_LAUNCHER -- requirements
Module: array_launcher

Interface
REQ-001 SHALL have parameter INSTR_DATA_WIDTH, default 32, meaning instruction word width.
REQ-002 SHALL have parameter INSTR_ADDR_WIDTH, default 6, meaning target instruction slot address width.
REQ-003 SHALL have parameter INSTR_HOPS_WIDTH, default 4, meaning cell hop-count width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning WAIT-state cycles before timeout (only when the timeout macro is defined).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit, meaning a pulse that begins a launch.
REQ-008 SHALL have port prog_valid, input, 1 bit, meaning the host program beat is valid.
REQ-009 SHALL have port prog_ready, output, 1 bit, meaning the launcher accepts a beat.
REQ-010 SHALL have port prog_last, input, 1 bit, meaning the final beat of the program.
REQ-011 SHALL have ports prog_data / prog_addr / prog_hops, inputs, INSTR_DATA/ADDR/HOPS_WIDTH, meaning the beat payload.
REQ-012 SHALL have ports instr_data_out / instr_addr_out / instr_hops_out, outputs, same widths, meaning the registered instruction bus to the first cell.
REQ-013 SHALL have port instr_en_out, output, 1 bit, meaning the instruction bus is valid this cycle.
REQ-014 SHALL have port call_out, output, 1 bit, meaning the call pulse into the cell chain.
REQ-015 SHALL have port ret_in, input, 1 bit, meaning the sticky return level from the cell chain.
REQ-016 SHALL have ports busy, done and error, outputs, 1 bit each, meaning status.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CALL, WAIT, DONE and ERROR.
REQ-018 IDLE: start=1 SHALL move to LOAD; start SHALL be ignored in every other state.
REQ-019 LOAD: prog_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-020 Each handshake (prog_valid & prog_ready) SHALL register the payload onto instr_*_out with instr_en_out=1 in the next cycle, 1-cycle latency, one beat per cycle, back-to-back allowed.
REQ-021 A cycle with no handshake SHALL drive instr_en_out=0; instr data/addr/hops SHALL hold their last value.
REQ-022 A handshake with prog_last=1 SHALL move to CALL; a zero-beat program is impossible, since LOAD exits only on a last beat.
REQ-023 CALL SHALL assert call_out for exactly 1 cycle, the cycle after the last instr_en_out, then move to WAIT.
REQ-024 ret_q SHALL register ret_in every cycle; completion SHALL be the rising edge (ret_in & ~ret_q) seen in WAIT only.
REQ-025 A ret_in already high on WAIT entry SHALL NOT complete the launch.
REQ-026 Rising edges outside WAIT SHALL be ignored.
REQ-027 WAIT with a rising edge SHALL move to DONE; DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-028 busy SHALL be 1 in LOAD, CALL and WAIT, and 0 otherwise.
REQ-029 error SHALL be set on entry to ERROR, stay set while in ERROR, and clear on start; start in ERROR SHALL move to LOAD.

Reset
REQ-030 Asserting rst_n low at any time, including mid-LOAD or mid-WAIT, SHALL force IDLE and zero instr_*_out, instr_en_out, call_out, prog_ready, busy, done, error, ret_q and the timeout counter.
REQ-031 A beat offered during reset SHALL NOT be consumed.

Configuration
REQ-032 Macro ARRAY_LAUNCHER_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES without a rising edge, the FSM SHALL move to ERROR.
REQ-033 A rising edge in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win, moving to DONE.
REQ-034 Macro undefined: WAIT SHALL wait indefinitely, error SHALL be tied 0, ERROR SHALL be unreachable, and no counter SHALL be built.

Structure
REQ-035 The package array_launcher_pkg SHALL hold the width defaults, TIMEOUT_CYCLES default and the state enum typedef.
REQ-036 The timeout counter SHALL be a sub-module, launch_timer (clear, enable, expired), instantiated only under ARRAY_LAUNCHER_TIMEOUT_EN.

Verification
REQ-037 Start, then 3 back-to-back beats (data 0xA1,0xA2,0xA3, addr 1,2,3, hops 0, last on 3rd) -> instr_en_out high 3 cycles with matching payload, call_out 1 cycle later, busy=1.
REQ-038 prog_valid gapped (1,0,1, last) -> instr_en_out pattern 1,0,1; data held during the gap.
REQ-039 ret_in held high from before start -> no done; ret_in dropped then raised in WAIT -> done pulse 1 cycle after the edge, then IDLE.
REQ-040 rst_n pulsed low mid-LOAD after 1 beat -> all outputs 0 asynchronously; new start reloads a full program correctly.
REQ-041 Macro defined, TIMEOUT_CYCLES=8, ret_in never rises -> error=1 and busy=0 after 8 WAIT cycles; next start clears error and enters LOAD.
REQ-042 Macro defined, rising edge coincident with the 8th WAIT cycle -> done=1, error=0.

Source files
------------

// File: rtl/array_launcher_pkg.sv
// Shared defaults and FSM state encoding for the array launcher.
// Build option: ARRAY_LAUNCHER_TIMEOUT_EN enables the WAIT-state timeout.
package array_launcher_pkg;

  localparam int DEF_INSTR_DATA_WIDTH = 32;
  localparam int DEF_INSTR_ADDR_WIDTH = 6;
  localparam int DEF_INSTR_HOPS_WIDTH = 4;
  localparam int DEF_TIMEOUT_CYCLES   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALL  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/launch_timer.sv
// WAIT-state cycle counter; expired flags the cycle whose count reaches TIMEOUT_CYCLES.
// Only instantiated when ARRAY_LAUNCHER_TIMEOUT_EN is defined.
module launch_timer
  import array_launcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // This cycle's increment is the one that reaches the limit.
  assign expired = enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/array_launcher.sv
// Streams a host program onto the cell-chain instruction bus, fires a call pulse and
// waits for the chain's return edge. Build option: ARRAY_LAUNCHER_TIMEOUT_EN.
module array_launcher
  import array_launcher_pkg::*;
#(
  parameter int INSTR_DATA_WIDTH = DEF_INSTR_DATA_WIDTH,
  parameter int INSTR_ADDR_WIDTH = DEF_INSTR_ADDR_WIDTH,
  parameter int INSTR_HOPS_WIDTH = DEF_INSTR_HOPS_WIDTH,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        prog_valid,
  output logic                        prog_ready,
  input  logic                        prog_last,
  input  logic [INSTR_DATA_WIDTH-1:0] prog_data,
  input  logic [INSTR_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INSTR_HOPS_WIDTH-1:0] prog_hops,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        instr_en_out,
  output logic                        call_out,
  input  logic                        ret_in,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  state_t r_state;
  state_t w_next;

  logic                        r_ret_q;
  logic                        r_call_out;
  logic                        r_instr_en;
  logic [INSTR_DATA_WIDTH-1:0] r_instr_data;
  logic [INSTR_ADDR_WIDTH-1:0] r_instr_addr;
  logic [INSTR_HOPS_WIDTH-1:0] r_instr_hops;

  logic w_hs;
  logic w_rise;
  logic w_expired;

  assign w_hs   = prog_valid & prog_ready;
  assign w_rise = ret_in & ~r_ret_q;

`ifdef ARRAY_LAUNCHER_TIMEOUT_EN
  launch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_launch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (r_state != ST_WAIT),
    .enable (r_state == ST_WAIT),
    .expired(w_expired)
  );

  assign error = (r_state == ST_ERROR);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expired        = 1'b0;
  assign error            = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_hs && prog_last) w_next = ST_CALL;
      ST_CALL:  w_next = ST_WAIT;
      // A return edge beats a timeout landing in the same cycle.
      ST_WAIT: begin
        if (w_rise) begin
          w_next = ST_DONE;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: if (start) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ret_q      <= 1'b0;
      r_call_out   <= 1'b0;
      r_instr_en   <= 1'b0;
      r_instr_data <= '0;
      r_instr_addr <= '0;
      r_instr_hops <= '0;
    end else begin
      r_state    <= w_next;
      r_ret_q    <= ret_in;
      // Registered so the call trails the final bus beat by one cycle.
      r_call_out <= (r_state == ST_CALL);
      r_instr_en <= w_hs;
      if (w_hs) begin
        r_instr_data <= prog_data;
        r_instr_addr <= prog_addr;
        r_instr_hops <= prog_hops;
      end
    end
  end

  assign prog_ready     = (r_state == ST_LOAD);
  assign busy           = (r_state == ST_LOAD) || (r_state == ST_CALL) || (r_state == ST_WAIT);
  assign done           = (r_state == ST_DONE);
  assign call_out       = r_call_out;
  assign instr_en_out   = r_instr_en;
  assign instr_data_out = r_instr_data;
  assign instr_addr_out = r_instr_addr;
  assign instr_hops_out = r_instr_hops;

endmodule

// File: tb/tb_array_launcher.sv
// Randomized self-checking bench for array_launcher; expectations come from a
// launch-level timeline model (beats, gaps, wait length) kept in the bench.
`timescale 1ns/1ps
module tb_array_launcher;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int HW = 4;
  localparam int TO = 8;
`ifdef ARRAY_LAUNCHER_TIMEOUT_EN
  localparam int MAX_W = TO;
`else
  localparam int MAX_W = 12;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          prog_valid;
  logic          prog_ready;
  logic          prog_last;
  logic [DW-1:0] prog_data;
  logic [AW-1:0] prog_addr;
  logic [HW-1:0] prog_hops;
  logic [DW-1:0] instr_data_out;
  logic [AW-1:0] instr_addr_out;
  logic [HW-1:0] instr_hops_out;
  logic          instr_en_out;
  logic          call_out;
  logic          ret_in;
  logic          busy;
  logic          done;
  logic          error;

  array_launcher #(
    .INSTR_DATA_WIDTH(DW),
    .INSTR_ADDR_WIDTH(AW),
    .INSTR_HOPS_WIDTH(HW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .prog_valid    (prog_valid),
    .prog_ready    (prog_ready),
    .prog_last     (prog_last),
    .prog_data     (prog_data),
    .prog_addr     (prog_addr),
    .prog_hops     (prog_hops),
    .instr_data_out(instr_data_out),
    .instr_addr_out(instr_addr_out),
    .instr_hops_out(instr_hops_out),
    .instr_en_out  (instr_en_out),
    .call_out      (call_out),
    .ret_in        (ret_in),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last accepted payload and the program to send next.
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_addr;
  logic [HW-1:0] exp_hops;
  logic [DW-1:0] pd[8];
  logic [AW-1:0] pa[8];
  logic [HW-1:0] ph[8];
  int            gap[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic en);
    chk({tag, ".en"},   instr_en_out,   en);
    chk({tag, ".data"}, instr_data_out, exp_data);
    chk({tag, ".addr"}, instr_addr_out, exp_addr);
    chk({tag, ".hops"}, instr_hops_out, exp_hops);
  endtask

  task automatic do_start(input bit ret_pre);
    ret_in = ret_pre;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("load.ready", prog_ready, 1'b1);
    chk("load.busy",  busy,       1'b1);
    chk("load.err",   error,      1'b0);
  endtask

  // From LOAD: send n beats with gaps, expect call, raise ret in WAIT cycle w.
  task automatic body(input int n, input int w, input bit noise);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        prog_valid = 1'b0;
        prog_last  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        prog_data  = $urandom;
        step();
        chk_bus("gap", 1'b0);
        chk("gap.ready", prog_ready, 1'b1);
      end
      prog_valid = 1'b1;
      prog_data  = pd[i];
      prog_addr  = pa[i];
      prog_hops  = ph[i];
      prog_last  = (i == n - 1);
      step();
      exp_data = pd[i];
      exp_addr = pa[i];
      exp_hops = ph[i];
      chk_bus("beat", 1'b1);
      chk("beat.ready", prog_ready, (i != n - 1));
      chk("beat.call",  call_out,   1'b0);
      chk("beat.busy",  busy,       1'b1);
    end
    prog_valid = noise;
    prog_last  = noise;
    prog_data  = $urandom;
    step();
    chk_bus("call", 1'b0);
    chk("call.pulse", call_out, 1'b1);
    chk("call.busy",  busy,     1'b1);
    for (int i = 1; i < w; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == w - 1) ret_in = 1'b0;
      step();
      chk_bus("wait", 1'b0);
      chk("wait.call", call_out, 1'b0);
      chk("wait.done", done,     1'b0);
      chk("wait.busy", busy,     1'b1);
      chk("wait.err",  error,    1'b0);
    end
    start  = 1'b0;
    ret_in = 1'b1;
    step();
    chk("done.pulse", done,  1'b1);
    chk("done.busy",  busy,  1'b0);
    chk("done.err",   error, 1'b0);
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    step();
    chk("idle.done",  done,       1'b0);
    chk("idle.busy",  busy,       1'b0);
    chk("idle.ready", prog_ready, 1'b0);
    chk_bus("idle", 1'b0);
  endtask

  task automatic rand_prog(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      pd[i]  = $urandom;
      pa[i]  = AW'($urandom);
      ph[i]  = HW'($urandom);
      gap[i] = $urandom_range(0, max_gap);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"},    instr_en_out,   1'b0);
    chk({tag, ".data"},  instr_data_out, '0);
    chk({tag, ".addr"},  instr_addr_out, '0);
    chk({tag, ".hops"},  instr_hops_out, '0);
    chk({tag, ".call"},  call_out,       1'b0);
    chk({tag, ".ready"}, prog_ready,     1'b0);
    chk({tag, ".busy"},  busy,           1'b0);
    chk({tag, ".done"},  done,           1'b0);
    chk({tag, ".err"},   error,          1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; prog_valid = 1'b1; prog_last = 1'b1;
    prog_data = 32'h5; prog_addr = 6'd5; prog_hops = 4'd5; ret_in = 1'b0;
    exp_data = '0; exp_addr = '0; exp_hops = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1; start = 1'b0;
    step();
    prog_valid = 1'b0; prog_last = 1'b0;
    chk_all_zero("post_rst");

    // Three back-to-back beats.
    pd[0] = 32'hA1; pd[1] = 32'hA2; pd[2] = 32'hA3;
    pa[0] = 6'd1;   pa[1] = 6'd2;   pa[2] = 6'd3;
    ph[0] = 4'd0;   ph[1] = 4'd0;   ph[2] = 4'd0;
    gap[0] = 0; gap[1] = 0; gap[2] = 0;
    do_start(1'b0);
    body(3, 2, 1'b0);

    // Gapped valid: 1,0,1(last).
    rand_prog(2, 0);
    gap[1] = 1;
    do_start(1'b0);
    body(2, 3, 1'b0);

    // Return already high before start must not complete the launch.
    rand_prog(1, 0);
    do_start(1'b1);
    body(1, 4, 1'b0);

    // Asynchronous reset mid-LOAD after one beat.
    do_start(1'b0);
    prog_valid = 1'b1; prog_last = 1'b0;
    prog_data = 32'h55; prog_addr = 6'd9; prog_hops = 4'd3;
    step();
    exp_data = 32'h55; exp_addr = 6'd9; exp_hops = 4'd3;
    chk_bus("mid.beat", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_data = '0; exp_addr = '0; exp_hops = '0;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prog_valid = 1'b0;
    step();
    chk_all_zero("rst_release");
    rand_prog(3, 1);
    do_start(1'b0);
    body(3, 2, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_prog(n, 2);
      do_start(1'($urandom_range(0, 1)));
      body(n, $urandom_range(2, MAX_W), 1'b1);
    end

`ifdef ARRAY_LAUNCHER_TIMEOUT_EN
    // Return never rises: ERROR after TO WAIT cycles.
    do_start(1'b0);
    prog_valid = 1'b1; prog_last = 1'b1;
    prog_data = 32'hBEEF; prog_addr = 6'd7; prog_hops = 4'd2;
    step();
    exp_data = 32'hBEEF; exp_addr = 6'd7; exp_hops = 4'd2;
    chk_bus("to.beat", 1'b1);
    prog_valid = 1'b0; prog_last = 1'b0;
    step();
    chk("to.call", call_out, 1'b1);
    for (int i = 1; i < TO; i++) begin
      step();
      chk("to.busy", busy,  1'b1);
      chk("to.err0", error, 1'b0);
    end
    step();
    chk("to.err",   error, 1'b1);
    chk("to.idle",  busy,  1'b0);
    chk("to.ndone", done,  1'b0);
    step();
    chk("to.hold", error, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to.clear", error,      1'b0);
    chk("to.ready", prog_ready, 1'b1);
    chk("to.busy2", busy,       1'b1);
    rand_prog(1, 0);
    body(1, 3, 1'b0);

    // Return edge coincident with the final WAIT cycle wins.
    rand_prog(2, 1);
    do_start(1'b0);
    body(2, TO, 1'b0);
`else
    // Without the timeout, WAIT persists well past any limit.
    rand_prog(1, 0);
    do_start(1'b0);
    body(1, 20, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
